// File: rtl/wb_bus_ctrl.sv
// Wishbone slave-side bus controller: routes ZAP CPU cycles to MADAM/CLIO registers
// or the external memory port, with wait states, registered ack and a memory watchdog.
module wb_bus_ctrl #(
  parameter logic [31:0] MADAM_BASE = 32'h03300000,
  parameter logic [31:0] CLIO_BASE  = 32'h03400000,
  parameter int unsigned REG_WAIT   = 1,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hBADACCE5
) (
  input  logic        sys_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        madam_rd,
  output logic        madam_wr,
  output logic        clio_rd,
  output logic        clio_wr,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic [31:0] madam_dout,
  input  logic [31:0] clio_dout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, REG, MEM, ACK} state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(REG_WAIT);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        madam_sel_q;
  logic [3:0]  wcnt_q;
  logic [15:0] tcnt_q;
  logic [31:0] rdat_q;
  logic        ack_q;
  logic        madam_rd_q, madam_wr_q, clio_rd_q, clio_wr_q;
  logic        mem_req_q;
  logic        bus_err_q;
  logic [31:0] err_addr_q;

  logic hit_madam, hit_clio;

  assign hit_madam = (i_wb_adr[31:16] == MADAM_BASE[31:16]);
  assign hit_clio  = (i_wb_adr[31:16] == CLIO_BASE[31:16]);

  // Ack is raised on the edge leaving ACK, so IDLE must ignore the master while it is still high.
  always_ff @(posedge sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      madam_sel_q <= 1'b0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      rdat_q      <= '0;
      ack_q       <= 1'b0;
      madam_rd_q  <= 1'b0;
      madam_wr_q  <= 1'b0;
      clio_rd_q   <= 1'b0;
      clio_wr_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      madam_rd_q <= 1'b0;
      madam_wr_q <= 1'b0;
      clio_rd_q  <= 1'b0;
      clio_wr_q  <= 1'b0;
      ack_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb && !ack_q) begin
            addr_q <= i_wb_adr;
            wdat_q <= i_wb_dat;
            sel_q  <= i_wb_sel;
            we_q   <= i_wb_we;
            if (hit_madam || hit_clio) begin
              state_q     <= REG;
              wcnt_q      <= WAIT_INIT;
              madam_sel_q <= hit_madam;
              madam_rd_q  <= hit_madam & ~i_wb_we;
              madam_wr_q  <= hit_madam & i_wb_we;
              clio_rd_q   <= hit_clio & ~i_wb_we;
              clio_wr_q   <= hit_clio & i_wb_we;
            end else begin
              state_q   <= MEM;
              tcnt_q    <= '0;
              mem_req_q <= 1'b1;
            end
          end
        end
        REG: begin
          if (wcnt_q == 4'd0) begin
            if (!we_q) rdat_q <= madam_sel_q ? madam_dout : clio_dout;
            state_q <= ACK;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (!we_q) rdat_q <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= ACK;
          end else if (tcnt_q == TMO_LAST) begin
            if (!we_q) rdat_q <= ERR_DATA;
            if (!bus_err_q) begin
              bus_err_q  <= 1'b1;
              err_addr_q <= addr_q;
            end
            mem_req_q <= 1'b0;
            state_q   <= ACK;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        ACK: begin
          ack_q   <= i_wb_cyc;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_dat  = rdat_q;
  assign o_wb_ack  = ack_q;
  assign madam_rd  = madam_rd_q;
  assign madam_wr  = madam_wr_q;
  assign clio_rd   = clio_rd_q;
  assign clio_wr   = clio_wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdat_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdat_q;
  assign mem_sel   = sel_q;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;

endmodule
